// File: rtl/ntt_butterfly_iter.sv
// rtl/ntt_butterfly_iter.sv - iterative Cooley-Tukey NTT butterfly with bit-serial modular multiplier
module ntt_butterfly_iter #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] in_a,
    input  logic [D_WIDTH-1:0] in_b,
    input  logic [D_WIDTH-1:0] in_w,
    input  logic [D_WIDTH-1:0] modulus,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_sum,
    output logic [D_WIDTH-1:0] out_diff
);

    localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands latched at accept so upstream may change them afterwards
    logic [D_WIDTH-1:0] a_r;
    logic [D_WIDTH-1:0] b_r;
    logic [D_WIDTH-1:0] w_r;
    logic [D_WIDTH-1:0] q_r;
    logic [D_WIDTH-1:0] acc_r;
    logic [CW-1:0]      cnt_r;
    logic [D_WIDTH-1:0] sum_r;
    logic [D_WIDTH-1:0] diff_r;

    // One extra bit of headroom: 2*acc and t+b stay below 2q <= 2^(D_WIDTH+1)
    logic [D_WIDTH:0]   q_ext;
    logic [D_WIDTH:0]   dbl;
    logic [D_WIDTH:0]   dbl_red;
    logic [D_WIDTH:0]   add;
    logic [D_WIDTH:0]   add_red;
    logic [D_WIDTH-1:0] prod;
    logic [D_WIDTH:0]   a_plus_p;
    logic [D_WIDTH:0]   sum_red;
    logic [D_WIDTH-1:0] sum_val;
    logic [D_WIDTH-1:0] diff_val;

    logic accept;
    logic last_bit;
    logic release_out;

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign out_sum     = sum_r;
    assign out_diff    = diff_r;

    assign accept      = (state == IDLE) && in_valid;
    assign last_bit    = (cnt_r == '0);
    assign release_out = (state == DONE) && out_ready;

    // One interleaved multiplier step (MSB first) plus the final ModAdd/ModSub on the product
    always_comb begin
        q_ext    = {1'b0, q_r};
        dbl      = {acc_r, 1'b0};
        dbl_red  = (dbl >= q_ext) ? (dbl - q_ext) : dbl;
        add      = w_r[cnt_r] ? (dbl_red + {1'b0, b_r}) : dbl_red;
        add_red  = (add >= q_ext) ? (add - q_ext) : add;
        prod     = D_WIDTH'(add_red);
        a_plus_p = {1'b0, a_r} + {1'b0, prod};
        sum_red  = (a_plus_p >= q_ext) ? (a_plus_p - q_ext) : a_plus_p;
        sum_val  = D_WIDTH'(sum_red);
        // Wrapping D_WIDTH arithmetic gives the correct residue since the true result is below q
        diff_val = (a_r >= prod) ? (a_r - prod) : (a_r - prod + q_r);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = MUL;
                end
            end
            MUL: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, multiplier accumulator/counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            w_r    <= '0;
            q_r    <= '0;
            acc_r  <= '0;
            cnt_r  <= '0;
            sum_r  <= '0;
            diff_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_r   <= in_a;
                        b_r   <= in_b;
                        w_r   <= in_w;
                        q_r   <= modulus;
                        acc_r <= '0;
                        cnt_r <= CNT_LAST;
                    end
                end
                MUL: begin
                    acc_r <= prod;
                    if (last_bit) begin
                        sum_r  <= sum_val;
                        diff_r <= diff_val;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_butterfly_iter.sv
// tb/tb_ntt_butterfly_iter.sv - scoreboard testbench for ntt_butterfly_iter
module tb_ntt_butterfly_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv;
    logic        ordy;
    logic        wide;
    logic [15:0] a, b, w, q;

    logic        ir8, ov8, ir16, ov16;
    logic [7:0]  s8, d8;
    logic [15:0] s16, d16;

    logic        c_ir, c_ov;
    logic [15:0] c_sum, c_diff;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    ntt_butterfly_iter #(.D_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv & ~wide), .in_ready(ir8),
        .in_a(a[7:0]), .in_b(b[7:0]), .in_w(w[7:0]), .modulus(q[7:0]),
        .out_valid(ov8), .out_ready(ordy),
        .out_sum(s8), .out_diff(d8)
    );

    ntt_butterfly_iter #(.D_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv & wide), .in_ready(ir16),
        .in_a(a), .in_b(b), .in_w(w), .modulus(q),
        .out_valid(ov16), .out_ready(ordy),
        .out_sum(s16), .out_diff(d16)
    );

    assign c_ir   = wide ? ir16 : ir8;
    assign c_ov   = wide ? ov16 : ov8;
    assign c_sum  = wide ? s16 : {8'h00, s8};
    assign c_diff = wide ? d16 : {8'h00, d8};

    function automatic logic [31:0] gold(input int unsigned ga, gb, gw, gq);
        longint unsigned p, s, d;
        p = (longint'(gw) * longint'(gb)) % longint'(gq);
        s = (longint'(ga) + p) % longint'(gq);
        d = (longint'(ga) + longint'(gq) - p) % longint'(gq);
        return {s[15:0], d[15:0]};
    endfunction

    task automatic op(input logic [15:0] ta, tb_, tw, tq, input logic [15:0] es, ed,
                      input int stall, input int exp_lat);
        int n;
        logic [31:0] exp;
        a = ta; b = tb_; w = tw; q = tq; iv = 1'b1;
        n = 0;
        while (!c_ir && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (c_ir !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait in_ready=%b required=1", c_ir);
            iv = 1'b0;
            return;
        end
        @(posedge clk); #1;
        iv = 1'b0;
        a = 16'($urandom); b = 16'($urandom); w = 16'($urandom); q = 16'($urandom);
        sb.push_back({es, ed});
        n = 0;
        while (!c_ov && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== exp_lat || c_ov !== 1'b1) begin
            errors++;
            $display("FAIL latency got=%0d required=%0d", n, exp_lat);
            if (c_ov !== 1'b1) return;
        end
        exp = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            checks++;
            if (c_sum !== exp[31:16] || c_diff !== exp[15:0] || c_ir !== 1'b0 || c_ov !== 1'b1) begin
                errors++;
                $display("FAIL hold cycle=%0d sum=%0d diff=%0d ir=%b ov=%b required sum=%0d diff=%0d ir=0 ov=1",
                         i, c_sum, c_diff, c_ir, c_ov, exp[31:16], exp[15:0]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({c_sum, c_diff} !== exp) begin
            errors++;
            $display("FAIL result a=%0d b=%0d w=%0d q=%0d sum=%0d diff=%0d required sum=%0d diff=%0d",
                     ta, tb_, tw, tq, c_sum, c_diff, exp[31:16], exp[15:0]);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++;
        if (c_ir !== 1'b1 || c_ov !== 1'b0) begin
            errors++;
            $display("FAIL release ir=%b ov=%b required ir=1 ov=0", c_ir, c_ov);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; wide = 1'b0;
        a = '0; b = '0; w = '0; q = 16'd17;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'd0 || d8 !== 8'd0 ||
            ir16 !== 1'b1 || ov16 !== 1'b0 || s16 !== 16'd0 || d16 !== 16'd0) begin
            errors++;
            $display("FAIL reset ir8=%b ov8=%b s8=%0d d8=%0d ir16=%b ov16=%b s16=%0d d16=%0d required 1 0 0 0 1 0 0 0",
                     ir8, ov8, s8, d8, ir16, ov16, s16, d16);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        wide = 1'b0;
        op(16'd3, 16'd5, 16'd4, 16'd17, 16'd6, 16'd0, 0, 8);
    endtask

    task automatic test_wrap();
        wide = 1'b0;
        op(16'd0, 16'd5, 16'd7, 16'd17, 16'd1, 16'd16, 1, 8);
        op(16'd2, 16'd16, 16'd16, 16'd17, 16'd3, 16'd1, 0, 8);
    endtask

    task automatic test_wide();
        wide = 1'b1;
        op(16'd12288, 16'd12288, 16'd12288, 16'd12289, 16'd0, 16'd12287, 0, 16);
        op(16'd100, 16'd555, 16'd0, 16'd12289, 16'd100, 16'd100, 2, 16);
        wide = 1'b0;
    endtask

    task automatic test_backpressure();
        wide = 1'b0;
        op(16'd9, 16'd11, 16'd13, 16'd17, 16'd16, 16'd2, 20, 8);
        op(16'd1, 16'd1, 16'd1, 16'd17, 16'd2, 16'd0, 0, 8);
    endtask

    task automatic test_reset_mid();
        int n;
        wide = 1'b0;
        a = 16'd3; b = 16'd5; w = 16'd4; q = 16'd17; iv = 1'b1;
        n = 0;
        while (!c_ir && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (c_ir !== 1'b1 || c_ov !== 1'b0 || c_sum !== 16'd0 || c_diff !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid ir=%b ov=%b sum=%0d diff=%0d required 1 0 0 0", c_ir, c_ov, c_sum, c_diff);
        end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (c_ov === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_drop valid_cycles=%0d required=0", n);
        end
        op(16'd7, 16'd3, 16'd2, 16'd17, 16'd13, 16'd1, 0, 8);
    endtask

    task automatic test_sweep();
        logic [31:0] g;
        wide = 1'b0;
        for (int ia = 0; ia < 17; ia++)
            for (int ib = 0; ib < 17; ib++)
                for (int iw = 0; iw < 17; iw++) begin
                    g = gold(ia, ib, iw, 17);
                    op(16'(ia), 16'(ib), 16'(iw), 16'd17, g[31:16], g[15:0],
                       int'($urandom_range(0, 2)), 8);
                end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_wide();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
